pixel_capture_param: RTL and testbench
======================================

PIXEL_CAPTURE_PARAM -- requirements
Module: pixel_capture_param

Interface
REQ-001 SHALL have parameter FMT, default 0, pixel format: 0 = RGB444 (xR/GB byte pair, 12-bit out), 1 = RGB565 (16-bit out).
REQ-002 SHALL have parameter H_ACTIVE, default 640, maximum sensor pixels per line that are accepted.
REQ-003 SHALL have parameter V_ACTIVE, default 480, maximum lines per frame that are accepted.
REQ-004 SHALL have parameter DECIM, default 1, legal values 1/2/4, subsampling factor applied to both columns and rows.
REQ-005 SHALL have parameter ADDR_W, default 19, write-address width; it SHALL hold (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)-1.
REQ-006 SHALL derive localparam PIX_W = 12 when FMT=0, else 16.
REQ-007 pclk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 D  input  8  camera data byte.
REQ-010 vsync  input  1  frame sync, high between frames.
REQ-011 href  input  1  line valid, bytes valid while high.
REQ-012 RGB  output  PIX_W  assembled pixel.
REQ-013 wr_addr  output  ADDR_W  frame-buffer linear address of RGB.
REQ-014 wr_en  output  1  one-cycle write strobe qualifying RGB/wr_addr.
REQ-015 frame_done  output  1  one-cycle pulse at end of a frame that wrote at least one pixel.
REQ-016 pixel_err  output  1  sticky flag: line ended on an odd byte.

Function
REQ-017 SHALL implement states IDLE, ARMED, BYTE0, BYTE1.
REQ-018 IDLE: after reset; SHALL ignore href; SHALL go to ARMED when sampled vsync=1.
REQ-019 ARMED: SHALL wait for vsync=0 and href=1 to enter BYTE0; the byte present on that edge is byte 0.
REQ-020 BYTE0 with href=1 SHALL latch byte 0 and move to BYTE1; BYTE1 with href=1 SHALL form a pixel and return to BYTE0.
REQ-021 FMT=0: RGB = {byte0[3:0], byte1[7:4], byte1[3:0]}; FMT=1: RGB = {byte0, byte1}.
REQ-022 Pixel SHALL be written (RGB, wr_addr, wr_en=1 registered, visible the cycle after byte 1 is sampled) only if col < H_ACTIVE, row < V_ACTIVE, col mod DECIM = 0, row mod DECIM = 0.
REQ-023 col SHALL count every completed pixel in the line (written or not); address counter SHALL increment only on a write; wr_addr equals the pre-increment value.
REQ-024 wr_en SHALL be 0 in every cycle with no write; RGB and wr_addr SHALL hold their last value when wr_en=0.
REQ-025 href falling (registered edge detect) SHALL clear col, increment row (saturating at V_ACTIVE), and return to BYTE0 awaiting next href.
REQ-026 href falling while in BYTE1 (odd byte count) SHALL discard the half pixel and set pixel_err.
REQ-027 vsync=1 in any state except IDLE SHALL clear col, row, address counter and enter ARMED; partial pixel discarded without error.
REQ-028 vsync rising edge SHALL pulse frame_done for one cycle iff the frame just ended had at least one write.
REQ-029 href=1 while vsync=1 SHALL produce no writes.
REQ-030 Address counter SHALL never exceed the last legal address; no wrap within a frame.

Reset
REQ-031 rst=1 SHALL force state IDLE, RGB=0, wr_addr=0, wr_en=0, frame_done=0, pixel_err=0, all counters and edge-detect registers 0.
REQ-032 rst asserted mid-line SHALL abort the line; no write from the interrupted pixel; capture resumes only after a fresh vsync high-low sequence.
REQ-033 rst SHALL take priority over vsync, href and all data.

Verification
REQ-034 FMT=0, after rst: href=1 with bytes 0xBC,0xDA, no prior vsync -> wr_en never asserts.
REQ-035 FMT=0, vsync 1->0, href=1, bytes 0xBC,0xDA,0x45,0x61 -> writes RGB=0xCDA @addr 0, then RGB=0x561 @addr 1, each wr_en one cycle.
REQ-036 H_ACTIVE=4: one line of 6 pixels -> exactly 4 writes, addr 0..3; next line's first write at addr 4.
REQ-037 Line of 3 bytes then href=0 -> one write, pixel_err=1 and stays 1 until rst.
REQ-038 DECIM=2, H_ACTIVE=4: two lines of 4 pixels -> writes only cols 0,2 of row 0 at addr 0,1; none for row 1.
REQ-039 FMT=1: bytes 0xBC,0xDA -> RGB=0xBCDA @addr 0; then vsync rises -> frame_done one cycle; next frame first write at addr 0.

Source files
------------

// File: rtl/pixel_capture_param_if.sv
// Camera byte stream in, frame-buffer write port out.
// The master side drives the sensor signals; the slave side is the capture block.
interface pixel_capture_param_if #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 19
);
  logic [7:0]        D;
  logic              vsync;
  logic              href;
  logic [PIX_W-1:0]  RGB;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              frame_done;
  logic              pixel_err;

  modport master (
    output D, vsync, href,
    input  RGB, wr_addr, wr_en, frame_done, pixel_err
  );

  modport slave (
    input  D, vsync, href,
    output RGB, wr_addr, wr_en, frame_done, pixel_err
  );
endinterface

// File: rtl/pixel_capture_param.sv
// Assembles camera byte pairs into RGB444/RGB565 pixels and writes a
// decimated, window-clipped image into a linear frame buffer.
module pixel_capture_param #(
  parameter int FMT      = 0,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 19
) (
  input logic pclk,
  input logic rst,
  pixel_capture_param_if.slave cam
);

  localparam int PIX_W = (FMT == 0) ? 12 : 16;
  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_MASK  = COL_W'(DECIM - 1);
  localparam logic [ROW_W-1:0]  ROW_MASK  = ROW_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((H_ACTIVE / DECIM) * (V_ACTIVE / DECIM) - 1);

  typedef enum logic [1:0] {IDLE, ARMED, BYTE0, BYTE1} state_e;

  state_e            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_done_q, frame_done_d;
  logic              pixel_err_q, pixel_err_d;
  logic              wrote_q, wrote_d;

  logic [PIX_W-1:0]  pixel;
  logic              vsync_rise;
  logic              href_fall;
  logic              in_window;

  if (FMT == 0) begin : g_rgb444
    assign pixel = {byte0_q[3:0], cam.D};
  end else begin : g_rgb565
    assign pixel = {byte0_q, cam.D};
  end

  assign vsync_rise = cam.vsync & ~vsync_q;
  assign href_fall  = href_q & ~cam.href;
  assign in_window  = (col_q < COL_W'(H_ACTIVE)) && (row_q < ROW_W'(V_ACTIVE)) &&
                      ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);

  always_comb begin
    state_d      = state_q;
    vsync_d      = cam.vsync;
    href_d       = cam.href;
    byte0_d      = byte0_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    rgb_d        = rgb_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    pixel_err_d  = pixel_err_q;
    wrote_d      = wrote_q;

    if (vsync_rise) begin
      frame_done_d = wrote_q;
      wrote_d      = 1'b0;
    end

    if (state_q == IDLE) begin
      if (cam.vsync) state_d = ARMED;
    end else if (cam.vsync) begin
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED, BYTE0: begin
          if (cam.href) begin
            byte0_d = cam.D;
            state_d = BYTE1;
          end else if (href_fall && state_q == BYTE0) begin
            col_d = '0;
            if (row_q != ROW_W'(V_ACTIVE)) row_d = row_q + ROW_W'(1);
          end
        end
        BYTE1: begin
          if (cam.href) begin
            if (in_window) begin
              rgb_d     = pixel;
              wr_addr_d = addr_q;
              wr_en_d   = 1'b1;
              wrote_d   = 1'b1;
              if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
            end
            if (col_q != COL_W'(H_ACTIVE)) col_d = col_q + COL_W'(1);
            state_d = BYTE0;
          end else if (href_fall) begin
            // Line ended halfway through a pixel: drop the lone byte.
            col_d       = '0;
            pixel_err_d = 1'b1;
            if (row_q != ROW_W'(V_ACTIVE)) row_d = row_q + ROW_W'(1);
            state_d     = BYTE0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte0_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      rgb_q        <= '0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_err_q  <= 1'b0;
      wrote_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      byte0_q      <= byte0_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      rgb_q        <= rgb_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      pixel_err_q  <= pixel_err_d;
      wrote_q      <= wrote_d;
    end
  end

  assign cam.RGB        = rgb_q;
  assign cam.wr_addr    = wr_addr_q;
  assign cam.wr_en      = wr_en_q;
  assign cam.frame_done = frame_done_q;
  assign cam.pixel_err  = pixel_err_q;

endmodule

// File: tb/tb_pixel_capture_param.sv
// Drives two differently parameterised capture blocks with one shared camera
// stream; checks them against hand-derived tables and a byte-counting model.
module tb_pixel_capture_param;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d_in = 8'h00;

  always #5 pclk = ~pclk;

  pixel_capture_param_if #(.PIX_W(12), .ADDR_W(4)) if_a ();
  pixel_capture_param_if #(.PIX_W(16), .ADDR_W(2)) if_b ();

  assign if_a.D = d_in;
  assign if_a.vsync = vsync;
  assign if_a.href = href;
  assign if_b.D = d_in;
  assign if_b.vsync = vsync;
  assign if_b.href = href;

  pixel_capture_param #(.FMT(0), .H_ACTIVE(4), .V_ACTIVE(4), .DECIM(1), .ADDR_W(4)) dut_a (
    .pclk(pclk), .rst(rst), .cam(if_a)
  );
  pixel_capture_param #(.FMT(1), .H_ACTIVE(4), .V_ACTIVE(4), .DECIM(2), .ADDR_W(2)) dut_b (
    .pclk(pclk), .rst(rst), .cam(if_b)
  );

  typedef struct {
    int fmt, h, v, dec;
    bit synced, started;
    int nbytes, line, nwrites;
    bit err, prev_vs, prev_hr;
    logic [7:0] b0;
    int rgb, addr;
    bit wen, fd;
  } model_t;

  typedef struct {
    bit rst, vs, hr;
    logic [7:0] d;
    bit wen;
    int rgb, addr;
    bit err, fd;
  } vec_t;

  model_t m[2];
  vec_t   tab_a[29];
  vec_t   tab_b[25];
  int     total = 0;
  int     bad = 0;

  function automatic vec_t mkv(bit r, bit vs, bit hr, logic [7:0] d,
                               bit wen, int rgb, int addr, bit err, bit fd);
    vec_t v;
    v.rst = r; v.vs = vs; v.hr = hr; v.d = d;
    v.wen = wen; v.rgb = rgb; v.addr = addr; v.err = err; v.fd = fd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: a line is a run of href-high bytes; every odd byte completes
  // pixel nbytes/2, written if it lands on the decimated, clipped grid.
  task automatic modelStep(input int k, input bit r, input bit vs, input bit hr,
                           input logic [7:0] d);
    int col;
    if (r) begin
      m[k].synced = 0; m[k].started = 0; m[k].nbytes = 0; m[k].line = 0;
      m[k].nwrites = 0; m[k].err = 0; m[k].prev_vs = 0; m[k].prev_hr = 0;
      m[k].b0 = 8'h00; m[k].rgb = 0; m[k].addr = 0; m[k].wen = 0; m[k].fd = 0;
      return;
    end
    m[k].wen = 0;
    m[k].fd = vs && !m[k].prev_vs && (m[k].nwrites > 0);
    if (vs) begin
      m[k].synced = 1; m[k].started = 0; m[k].nbytes = 0;
      m[k].line = 0; m[k].nwrites = 0;
    end else if (m[k].synced && hr) begin
      if (m[k].nbytes % 2 == 0) begin
        m[k].b0 = d;
      end else begin
        col = m[k].nbytes / 2;
        if (col < m[k].h && m[k].line < m[k].v &&
            col % m[k].dec == 0 && m[k].line % m[k].dec == 0) begin
          m[k].rgb = (m[k].fmt == 0) ? int'({m[k].b0[3:0], d}) : int'({m[k].b0, d});
          m[k].addr = m[k].nwrites;
          m[k].nwrites++;
          m[k].wen = 1;
        end
      end
      m[k].nbytes++;
      m[k].started = 1;
    end else if (m[k].synced && !hr && m[k].prev_hr && m[k].started) begin
      if (m[k].nbytes % 2 == 1) m[k].err = 1;
      if (m[k].line < m[k].v) m[k].line++;
      m[k].nbytes = 0;
    end
    m[k].prev_vs = vs;
    m[k].prev_hr = hr;
  endtask

  task automatic applyStimulus(input bit r, input bit vs, input bit hr, input logic [7:0] d);
    rst = r; vsync = vs; href = hr; d_in = d;
    @(posedge pclk);
    modelStep(0, r, vs, hr, d);
    modelStep(1, r, vs, hr, d);
    #1;
    checkOutput("model_a_wr_en", int'(if_a.wr_en), int'(m[0].wen));
    checkOutput("model_a_rgb", int'(if_a.RGB), m[0].rgb);
    checkOutput("model_a_wr_addr", int'(if_a.wr_addr), m[0].addr);
    checkOutput("model_a_frame_done", int'(if_a.frame_done), int'(m[0].fd));
    checkOutput("model_a_pixel_err", int'(if_a.pixel_err), int'(m[0].err));
    checkOutput("model_b_wr_en", int'(if_b.wr_en), int'(m[1].wen));
    checkOutput("model_b_rgb", int'(if_b.RGB), m[1].rgb);
    checkOutput("model_b_wr_addr", int'(if_b.wr_addr), m[1].addr);
    checkOutput("model_b_frame_done", int'(if_b.frame_done), int'(m[1].fd));
    checkOutput("model_b_pixel_err", int'(if_b.pixel_err), int'(m[1].err));
  endtask

  initial begin
    int wcount;
    int nb;
    logic [7:0] b_seq[8];

    m[0].fmt = 0; m[0].h = 4; m[0].v = 4; m[0].dec = 1;
    m[1].fmt = 1; m[1].h = 4; m[1].v = 4; m[1].dec = 2;
    modelStep(0, 1, 0, 0, 8'h00);
    modelStep(1, 1, 0, 0, 8'h00);

    // 12-bit instance: no-vsync start, one 6-pixel clipped line, odd line, next frame.
    tab_a[0]  = mkv(1, 0, 0, 8'h00, 0, 'h000, 0, 0, 0);
    tab_a[1]  = mkv(0, 0, 1, 8'hBC, 0, 'h000, 0, 0, 0);
    tab_a[2]  = mkv(0, 0, 1, 8'hDA, 0, 'h000, 0, 0, 0);
    tab_a[3]  = mkv(0, 0, 0, 8'h00, 0, 'h000, 0, 0, 0);
    tab_a[4]  = mkv(0, 1, 0, 8'h00, 0, 'h000, 0, 0, 0);
    tab_a[5]  = mkv(0, 0, 1, 8'hBC, 0, 'h000, 0, 0, 0);
    tab_a[6]  = mkv(0, 0, 1, 8'hDA, 1, 'hCDA, 0, 0, 0);
    tab_a[7]  = mkv(0, 0, 1, 8'h45, 0, 'hCDA, 0, 0, 0);
    tab_a[8]  = mkv(0, 0, 1, 8'h61, 1, 'h561, 1, 0, 0);
    tab_a[9]  = mkv(0, 0, 1, 8'h12, 0, 'h561, 1, 0, 0);
    tab_a[10] = mkv(0, 0, 1, 8'h34, 1, 'h234, 2, 0, 0);
    tab_a[11] = mkv(0, 0, 1, 8'h56, 0, 'h234, 2, 0, 0);
    tab_a[12] = mkv(0, 0, 1, 8'h78, 1, 'h678, 3, 0, 0);
    tab_a[13] = mkv(0, 0, 1, 8'h9A, 0, 'h678, 3, 0, 0);
    tab_a[14] = mkv(0, 0, 1, 8'hBC, 0, 'h678, 3, 0, 0);
    tab_a[15] = mkv(0, 0, 1, 8'hDE, 0, 'h678, 3, 0, 0);
    tab_a[16] = mkv(0, 0, 1, 8'hF0, 0, 'h678, 3, 0, 0);
    tab_a[17] = mkv(0, 0, 0, 8'h00, 0, 'h678, 3, 0, 0);
    tab_a[18] = mkv(0, 0, 1, 8'h0F, 0, 'h678, 3, 0, 0);
    tab_a[19] = mkv(0, 0, 1, 8'h21, 1, 'hF21, 4, 0, 0);
    tab_a[20] = mkv(0, 0, 1, 8'h33, 0, 'hF21, 4, 0, 0);
    tab_a[21] = mkv(0, 0, 0, 8'h00, 0, 'hF21, 4, 1, 0);
    tab_a[22] = mkv(0, 0, 0, 8'h00, 0, 'hF21, 4, 1, 0);
    tab_a[23] = mkv(0, 1, 0, 8'h00, 0, 'hF21, 4, 1, 1);
    tab_a[24] = mkv(0, 1, 0, 8'h00, 0, 'hF21, 4, 1, 0);
    tab_a[25] = mkv(0, 0, 1, 8'hAB, 0, 'hF21, 4, 1, 0);
    tab_a[26] = mkv(0, 0, 1, 8'hCD, 1, 'hBCD, 0, 1, 0);
    tab_a[27] = mkv(0, 0, 0, 8'h00, 0, 'hBCD, 0, 1, 0);
    tab_a[28] = mkv(1, 0, 0, 8'h00, 0, 'h000, 0, 0, 0);

    // 16-bit, decimate-by-2 instance: two 4-pixel lines, then frame_done and restart.
    tab_b[0]  = mkv(1, 0, 0, 8'h00, 0, 'h0000, 0, 0, 0);
    tab_b[1]  = mkv(0, 1, 0, 8'h00, 0, 'h0000, 0, 0, 0);
    tab_b[2]  = mkv(0, 0, 1, 8'hBC, 0, 'h0000, 0, 0, 0);
    tab_b[3]  = mkv(0, 0, 1, 8'hDA, 1, 'hBCDA, 0, 0, 0);
    tab_b[4]  = mkv(0, 0, 1, 8'h11, 0, 'hBCDA, 0, 0, 0);
    tab_b[5]  = mkv(0, 0, 1, 8'h22, 0, 'hBCDA, 0, 0, 0);
    tab_b[6]  = mkv(0, 0, 1, 8'h33, 0, 'hBCDA, 0, 0, 0);
    tab_b[7]  = mkv(0, 0, 1, 8'h44, 1, 'h3344, 1, 0, 0);
    tab_b[8]  = mkv(0, 0, 1, 8'h55, 0, 'h3344, 1, 0, 0);
    tab_b[9]  = mkv(0, 0, 1, 8'h66, 0, 'h3344, 1, 0, 0);
    tab_b[10] = mkv(0, 0, 0, 8'h00, 0, 'h3344, 1, 0, 0);
    b_seq[0] = 8'h77; b_seq[1] = 8'h88; b_seq[2] = 8'h99; b_seq[3] = 8'hAA;
    b_seq[4] = 8'hBB; b_seq[5] = 8'hCC; b_seq[6] = 8'hDD; b_seq[7] = 8'hEE;
    for (int i = 0; i < 8; i++) tab_b[11 + i] = mkv(0, 0, 1, b_seq[i], 0, 'h3344, 1, 0, 0);
    tab_b[19] = mkv(0, 0, 0, 8'h00, 0, 'h3344, 1, 0, 0);
    tab_b[20] = mkv(0, 1, 0, 8'h00, 0, 'h3344, 1, 0, 1);
    tab_b[21] = mkv(0, 1, 0, 8'h00, 0, 'h3344, 1, 0, 0);
    tab_b[22] = mkv(0, 0, 1, 8'h01, 0, 'h3344, 1, 0, 0);
    tab_b[23] = mkv(0, 0, 1, 8'h02, 1, 'h0102, 0, 0, 0);
    tab_b[24] = mkv(0, 0, 0, 8'h00, 0, 'h0102, 0, 0, 0);

    $display("[TB] table run, 12-bit instance");
    for (int i = 0; i < 29; i++) begin
      applyStimulus(tab_a[i].rst, tab_a[i].vs, tab_a[i].hr, tab_a[i].d);
      checkOutput($sformatf("tab_a[%0d].wr_en", i), int'(if_a.wr_en), int'(tab_a[i].wen));
      checkOutput($sformatf("tab_a[%0d].rgb", i), int'(if_a.RGB), tab_a[i].rgb);
      checkOutput($sformatf("tab_a[%0d].wr_addr", i), int'(if_a.wr_addr), tab_a[i].addr);
      checkOutput($sformatf("tab_a[%0d].pixel_err", i), int'(if_a.pixel_err), int'(tab_a[i].err));
      checkOutput($sformatf("tab_a[%0d].frame_done", i), int'(if_a.frame_done), int'(tab_a[i].fd));
    end

    $display("[TB] table run, 16-bit decimated instance");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(tab_b[i].rst, tab_b[i].vs, tab_b[i].hr, tab_b[i].d);
      checkOutput($sformatf("tab_b[%0d].wr_en", i), int'(if_b.wr_en), int'(tab_b[i].wen));
      checkOutput($sformatf("tab_b[%0d].rgb", i), int'(if_b.RGB), tab_b[i].rgb);
      checkOutput($sformatf("tab_b[%0d].wr_addr", i), int'(if_b.wr_addr), tab_b[i].addr);
      checkOutput($sformatf("tab_b[%0d].pixel_err", i), int'(if_b.pixel_err), int'(tab_b[i].err));
      checkOutput($sformatf("tab_b[%0d].frame_done", i), int'(if_b.frame_done), int'(tab_b[i].fd));
    end

    $display("[TB] reset in the middle of a line");
    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h5A);
    applyStimulus(1, 0, 1, 8'hA5);
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 8'(i * 17));
      wcount += int'(if_a.wr_en) + int'(if_b.wr_en);
    end
    applyStimulus(0, 0, 0, 8'h00);
    wcount += int'(if_a.wr_en) + int'(if_b.wr_en);
    checkOutput("rst_midline_writes", wcount, 0);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h9C);
    applyStimulus(0, 0, 1, 8'h3E);
    checkOutput("resume_wr_en", int'(if_a.wr_en), 1);
    checkOutput("resume_wr_addr", int'(if_a.wr_addr), 0);
    checkOutput("resume_rgb", int'(if_a.RGB), 'hC3E);
    applyStimulus(0, 0, 0, 8'h00);

    $display("[TB] href asserted during vsync");
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 8'(8'hF0 + i));
      wcount += int'(if_a.wr_en) + int'(if_b.wr_en);
    end
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("vsync_href_writes", wcount, 0);

    $display("[TB] randomized frames");
    applyStimulus(1, 0, 0, 8'h00);
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < int'($urandom_range(1, 3)); c++)
        applyStimulus(0, 1, ($urandom_range(0, 7) == 0), 8'($urandom));
      for (int c = 0; c < int'($urandom_range(0, 2)); c++)
        applyStimulus(0, 0, 0, 8'($urandom));
      for (int ln = 0; ln < int'($urandom_range(1, 6)); ln++) begin
        nb = $urandom_range(1, 12);
        for (int b = 0; b < nb; b++) applyStimulus(0, 0, 1, 8'($urandom));
        for (int c = 0; c < int'($urandom_range(1, 3)); c++)
          applyStimulus(0, 0, 0, 8'($urandom));
      end
    end
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
